// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives all four {a,b} combinations into a two-input
// gate unit, samples its seven outputs and scores them against the truth table.
module gate_sweep_checker #(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [6:0]       y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec,
    output logic [6:0]       fail_bits
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       ab_q, ab_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fv_q, fv_d;
    logic [6:0]       fb_q, fb_d;

    logic             ra, rb;
    logic [6:0]       ref_y;
    logic [6:0]       mask;

    assign ra = ab_q[1];
    assign rb = ab_q[0];

    // Reference truth table for the currently driven vector.
    assign ref_y = {~ra, ~(ra ^ rb), ra ^ rb, ~(ra | rb),
                    ~(ra & rb), ra | rb, ra & rb};
    assign mask  = y ^ ref_y;

    // Next-state and result-update logic for the sweep FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fb_d    = fb_q;
        unique case (state_q)
            S_IDLE: begin
                ab_d = 2'b00;
                if (start) begin
                    err_d   = '0;
                    fv_d    = 4'b0;
                    fb_d    = 7'b0;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
                    cnt_d   = SETTLE_L;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mask != 7'b0) begin
                    if (!(&err_q)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    fv_d = fv_q | (4'b0001 << idx_q);
                    fb_d = fb_q | mask;
                end
                if (idx_q == 2'd3) begin
                    ab_d    = 2'b00;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    ab_d    = idx_q + 2'd1;
                    cnt_d   = SETTLE_L;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 4'b0;
            fb_q    <= 7'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fb_q    <= fb_d;
        end
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_vec  = fv_q;
    assign fail_bits = fb_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed vectors against gate_sweep_checker with a
// good / y4-stuck / inverted gate model, plus start-hold and mid-sweep reset.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a, b, busy, done, pass;
    logic [7:0] err_cnt;
    logic [3:0] fail_vec;
    logic [6:0] fail_bits;
    logic [6:0] y;

    logic       a2, b2, busy2, done2, pass2;
    logic [0:0] err2;
    logic [3:0] fv2;
    logic [6:0] fb2;
    logic [6:0] y2;

    int mode = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         mode;
        logic [7:0] err;
        logic [3:0] fv;
        logic [6:0] fb;
        logic       pass;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    // Hand-written truth table, bit order {y6..y0}.
    function automatic logic [6:0] truth(input logic [1:0] i);
        logic [6:0] r;
        case (i)
            2'b00:   r = 7'b1101100;
            2'b01:   r = 7'b1010110;
            2'b10:   r = 7'b0010110;
            default: r = 7'b0100011;
        endcase
        return r;
    endfunction

    always_comb begin
        y = truth({a, b});
        if (mode == 1) y[4] = 1'b0;
        else if (mode == 2) y = ~y;
    end

    assign y2 = ~truth({a2, b2});

    gate_sweep_checker #(.SETTLE(2), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_vec(fail_vec), .fail_bits(fail_bits)
    );

    gate_sweep_checker #(.SETTLE(2), .ERR_W(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a2), .b(b2), .y(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_vec(fv2), .fail_bits(fb2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Start a sweep at edge k and follow cycles k+1..k+13.
    task automatic sweep(input bit hold);
        bit ok;
        logic [1:0] e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        ok = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            e = 2'((n - 1) / 3);
            if ({a, b} !== e || busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
        end
        chk("sweep_trace", 32'(ok), 32'd1);
        @(negedge clk);
        chk("done_k13", {29'd0, done, busy, a | b}, 32'b100);
    endtask

    initial begin
        bit seen;
        tbl[0] = '{0, 8'd0, 4'h0, 7'h00, 1'b1};
        tbl[1] = '{1, 8'd2, 4'b0110, 7'b0010000, 1'b0};
        tbl[2] = '{2, 8'd4, 4'hf, 7'h7f, 1'b0};
        tbl[3] = '{0, 8'd0, 4'h0, 7'h00, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state",
            {12'd0, a, b, busy, done, pass, err_cnt, fail_vec, fail_bits}, 32'd0);
        chk("reset_state_sat",
            {19'd0, a2, b2, busy2, done2, pass2, err2, fv2, fb2}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            sweep(1'b0);
            chk("err_cnt", 32'(err_cnt), 32'(tbl[i].err));
            chk("fail_vec", 32'(fail_vec), 32'(tbl[i].fv));
            chk("fail_bits", 32'(fail_bits), 32'(tbl[i].fb));
            chk("pass", 32'(pass), 32'(tbl[i].pass));
            chk("sat_results", {19'd0, pass2, err2, fv2, fb2},
                {19'd0, 1'b0, 1'b1, 4'hf, 7'h7f});
        end

        repeat (3) @(negedge clk);
        chk("idle_hold", {29'd0, pass, done, busy}, 32'b100);

        mode = 0;
        sweep(1'b1);
        @(negedge clk);
        chk("hold_k14", {30'd0, busy, done}, 32'b00);
        @(negedge clk);
        chk("hold_k15_busy", 32'(busy), 32'd1);
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("hold_second_done", 32'(seen), 32'd1);
        chk("hold_second_pass", 32'(pass), 32'd1);

        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 6; n++) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset",
            {12'd0, a, b, busy, done, pass, err_cnt, fail_vec, fail_bits}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", {29'd0, a, b, busy}, 32'd0);
        sweep(1'b0);
        chk("post_reset_pass", {23'd0, pass, err_cnt}, {23'd0, 1'b1, 8'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
